// File: rtl/apb_fifo_bridge_pkg.sv
// apb_fifo_bridge_pkg
//   Shared definitions for the APB-to-FIFO bridge: register byte addresses,
//   FSM state encoding and register bit positions.
//   The 0xC ERRCNT register exists only when APB_FIFO_BRIDGE_STATS_EN is defined.
package apb_fifo_bridge_pkg;

  localparam logic [31:0] ADDR_DATA   = 32'h0;
  localparam logic [31:0] ADDR_STATUS = 32'h4;
  localparam logic [31:0] ADDR_CTRL   = 32'h8;
  localparam logic [31:0] ADDR_ERRCNT = 32'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int STATUS_EMPTY_BIT  = 0;
  localparam int STATUS_FULL_BIT   = 1;
  localparam int CTRL_BLOCK_EN_BIT = 0;

  localparam int                   ERRCNT_W   = 8;
  localparam logic [ERRCNT_W-1:0]  ERRCNT_MAX = '1;

endpackage

// File: rtl/apb_fifo_bridge_decode.sv
// apb_fifo_bridge_decode
//   Combinational address decode for the bridge register map.
//   Ports:
//     paddr      in   byte address (word-aligned registers, exact match)
//     pwrite     in   transfer direction, used to flag writes to read-only STATUS
//     hit_data   out  DATA register selected
//     hit_status out  STATUS register selected
//     hit_ctrl   out  CTRL register selected
//     hit_errcnt out  ERRCNT register selected (APB_FIFO_BRIDGE_STATS_EN only)
//     unmapped   out  no register at this address
//     illegal    out  write to read-only STATUS
module apb_fifo_bridge_decode
  import apb_fifo_bridge_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  output logic              hit_data,
  output logic              hit_status,
  output logic              hit_ctrl,
`ifdef APB_FIFO_BRIDGE_STATS_EN
  output logic              hit_errcnt,
`endif
  output logic              unmapped,
  output logic              illegal
);

  // Zero-extend so the package constants compare correctly for any ADDR_W.
  logic [31:0] addr;
  assign addr = 32'(paddr);

  assign hit_data   = (addr == ADDR_DATA);
  assign hit_status = (addr == ADDR_STATUS);
  assign hit_ctrl   = (addr == ADDR_CTRL);

`ifdef APB_FIFO_BRIDGE_STATS_EN
  assign hit_errcnt = (addr == ADDR_ERRCNT);
  assign unmapped   = ~(hit_data | hit_status | hit_ctrl | hit_errcnt);
`else
  assign unmapped   = ~(hit_data | hit_status | hit_ctrl);
`endif

  assign illegal = hit_status & pwrite;

endmodule

// File: rtl/apb_fifo_bridge.sv
// apb_fifo_bridge
//   APB slave in front of a flip-flop FIFO. A write to DATA pushes one word,
//   a read from DATA pops one word; STATUS reports empty/full and CTRL.block_en
//   makes blocked DATA accesses stall (PREADY low) until the FIFO is ready or
//   the stall counter reaches TIMEOUT (TIMEOUT must be >= 1).
//   Optional: APB_FIFO_BRIDGE_STATS_EN adds 0xC ERRCNT, a saturating 8-bit
//   count of error responses (any write clears it).
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     psel, penable     APB select / access phase
//     pwrite, paddr     direction, byte address
//     pwdata            write data
//     prdata            read data, registered, held until the next read completes
//     pready, pslverr   registered completion / error response
//     fifo_push/_wdata  one-cycle push strobe and its data
//     fifo_pop          one-cycle pop strobe
//     fifo_rdata        FIFO head word (combinational from FIFO)
//     fifo_empty/_full  FIFO status
module apb_fifo_bridge
  import apb_fifo_bridge_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              fifo_push,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              fifo_pop,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_empty,
  input  logic              fifo_full
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [CNT_W-1:0]  stall_cnt;
  logic              block_en;

  logic              hit_data;
  logic              hit_status;
  logic              hit_ctrl;
  logic              unmapped;
  logic              illegal;
`ifdef APB_FIFO_BRIDGE_STATS_EN
  logic              hit_errcnt;
  logic [ERRCNT_W-1:0] errcnt;
  logic              err_resp;
`endif

  logic              idle_acc;
  logic              wait_act;
  logic              blocked;
  logic              idle_err;
  logic              wait_err;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] ctrl_word;

  apb_fifo_bridge_decode #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .paddr      (paddr),
    .pwrite     (pwrite),
    .hit_data   (hit_data),
    .hit_status (hit_status),
    .hit_ctrl   (hit_ctrl),
`ifdef APB_FIFO_BRIDGE_STATS_EN
    .hit_errcnt (hit_errcnt),
`endif
    .unmapped   (unmapped),
    .illegal    (illegal)
  );

  // First access-phase cycle seen in IDLE, or a still-selected stall in WAIT.
  assign idle_acc = (state == IDLE) & psel & penable;
  assign wait_act = (state == WAIT) & psel;

  // Only meaningful for DATA accesses: the direction that cannot proceed now.
  assign blocked = pwrite ? fifo_full : fifo_empty;

  assign idle_err = idle_acc & (unmapped | illegal | (hit_data & blocked & ~block_en));
  assign wait_err = wait_act & blocked & (stall_cnt == CNT_W'(TIMEOUT));

  // Strobes are combinational so the pop and the prdata capture of the
  // combinational FIFO head happen in the same cycle; WAIT is only ever
  // entered for DATA accesses, so it needs no address qualification.
  assign fifo_push  = ~rst & pwrite & ~fifo_full &
                      ((idle_acc & hit_data) | wait_act);
  assign fifo_pop   = ~rst & ~pwrite & ~fifo_empty &
                      ((idle_acc & hit_data) | wait_act);
  assign fifo_wdata = pwdata;

  always_comb begin
    status_word = '0;
    status_word[STATUS_EMPTY_BIT] = fifo_empty;
    status_word[STATUS_FULL_BIT]  = fifo_full;
    ctrl_word = '0;
    ctrl_word[CTRL_BLOCK_EN_BIT]  = block_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      block_en  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      case (state)
        IDLE: begin
          if (psel && penable) begin
            if (hit_data && blocked && block_en) begin
              state     <= WAIT;
              stall_cnt <= '0;
            end else begin
              state   <= RESP;
              pready  <= 1'b1;
              pslverr <= idle_err;
              if (!idle_err) begin
                if (hit_data) begin
                  if (!pwrite) prdata <= fifo_rdata;
                end else if (hit_status) begin
                  prdata <= status_word;
                end else if (hit_ctrl) begin
                  if (pwrite) block_en <= pwdata[CTRL_BLOCK_EN_BIT];
                  else        prdata   <= ctrl_word;
                end
`ifdef APB_FIFO_BRIDGE_STATS_EN
                else if (hit_errcnt && !pwrite) begin
                  prdata <= DATA_W'(errcnt);
                end
`endif
              end
            end
          end
        end
        WAIT: begin
          if (!psel) begin
            // Master abandoned the transfer: no strobe, no response.
            state <= IDLE;
          end else if (!blocked) begin
            state  <= RESP;
            pready <= 1'b1;
            if (!pwrite) prdata <= fifo_rdata;
          end else if (wait_err) begin
            state   <= RESP;
            pready  <= 1'b1;
            pslverr <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef APB_FIFO_BRIDGE_STATS_EN
  assign err_resp = idle_err | wait_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      errcnt <= '0;
    end else if (idle_acc && hit_errcnt && pwrite) begin
      errcnt <= '0;
    end else if (err_resp && (errcnt != ERRCNT_MAX)) begin
      errcnt <= errcnt + ERRCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_apb_fifo_bridge.sv
module tb_apb_fifo_bridge;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 15;
  localparam int DEPTH   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata, fifo_wdata, fifo_rdata;
  logic              pready, pslverr, fifo_push, fifo_pop, fifo_empty, fifo_full;

  always #5 clk = ~clk;

  apb_fifo_bridge #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .fifo_push (fifo_push),
    .fifo_wdata(fifo_wdata),
    .fifo_pop  (fifo_pop),
    .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full)
  );

  int vectors     = 0;
  int miscompares = 0;
  int tot_push    = 0;
  int tot_pop     = 0;
  int both_hi     = 0;

  always @(posedge clk) begin
    if (fifo_push) tot_push <= tot_push + 1;
    if (fifo_pop)  tot_pop  <= tot_pop + 1;
    if (fifo_push && fifo_pop) both_hi <= both_hi + 1;
  end

  // Results of the last transfer
  int          r_rdy, r_push, r_pop, r_scyc;
  logic [7:0]  r_rd, r_pdata;
  logic        r_err;

  // Reference model state
  logic [7:0]  q[$];
  logic        m_block_en;
  logic [7:0]  m_prdata;
  int          m_errcnt;

  // One APB transfer; rel >= 1 clears full/empty at that access cycle.
  task automatic apb_xfer(input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, input int rel);
    r_push = 0; r_pop = 0; r_rdy = -1; r_scyc = -1;
    r_pdata = '0; r_rd = '0; r_err = 1'b0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (cyc == rel) begin fifo_full = 1'b0; fifo_empty = 1'b0; end
      #1;
      if (fifo_push) begin r_push++; r_pdata = fifo_wdata; r_scyc = cyc; end
      if (fifo_pop)  begin r_pop++;  r_scyc = cyc; end
      if (pready) begin
        r_rdy = cyc; r_rd = prdata; r_err = pslverr;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = '0;
    pwdata = 8'h55; fifo_full = 1'b0; fifo_empty = 1'b1; fifo_rdata = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL reset_pready got=%b exp=0", pready); end
    vectors++; if (pslverr !== 1'b0) begin miscompares++; $display("FAIL reset_pslverr got=%b exp=0", pslverr); end
    vectors++; if (prdata !== 8'h00) begin miscompares++; $display("FAIL reset_prdata got=%h exp=00", prdata); end
    vectors++; if (fifo_push !== 1'b0 || fifo_pop !== 1'b0) begin miscompares++; $display("FAIL reset_strobes got=%b%b exp=00", fifo_push, fifo_pop); end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; rst = 1'b0;
    apb_xfer(1'b0, 4'h8, 8'h00, -1);
    vectors++; if (r_rd !== 8'h00 || r_err !== 1'b0 || r_rdy !== 2) begin miscompares++; $display("FAIL reset_ctrl rd=%h err=%b rdy=%0d exp 00/0/2", r_rd, r_err, r_rdy); end
  endtask

  task automatic test_write();
    fifo_full = 1'b0; fifo_empty = 1'b1;
    apb_xfer(1'b1, 4'h0, 8'h5A, -1);
    vectors++; if (r_push !== 1 || r_pdata !== 8'h5A) begin miscompares++; $display("FAIL write_push n=%0d data=%h exp 1/5a", r_push, r_pdata); end
    vectors++; if (r_rdy !== 2 || r_err !== 1'b0 || r_pop !== 0) begin miscompares++; $display("FAIL write_resp rdy=%0d err=%b pop=%0d exp 2/0/0", r_rdy, r_err, r_pop); end
  endtask

  task automatic test_read();
    fifo_full = 1'b0; fifo_empty = 1'b0; fifo_rdata = 8'hA5;
    apb_xfer(1'b0, 4'h0, 8'h00, -1);
    vectors++; if (r_pop !== 1 || r_push !== 0) begin miscompares++; $display("FAIL read_pop pop=%0d push=%0d exp 1/0", r_pop, r_push); end
    vectors++; if (r_rd !== 8'hA5 || r_rdy !== 2 || r_err !== 1'b0) begin miscompares++; $display("FAIL read_resp rd=%h rdy=%0d err=%b exp a5/2/0", r_rd, r_rdy, r_err); end
  endtask

  task automatic test_nonblock_err();
    fifo_full = 1'b1; fifo_empty = 1'b0;
    apb_xfer(1'b1, 4'h0, 8'h11, -1);
    vectors++; if (r_push !== 0 || r_rdy !== 2 || r_err !== 1'b1) begin miscompares++; $display("FAIL nonblock_full push=%0d rdy=%0d err=%b exp 0/2/1", r_push, r_rdy, r_err); end
  endtask

  task automatic test_status_ctrl();
    fifo_full = 1'b1; fifo_empty = 1'b0;
    apb_xfer(1'b0, 4'h4, 8'h00, -1);
    vectors++; if (r_rd !== 8'h02 || r_err !== 1'b0) begin miscompares++; $display("FAIL status_rd rd=%h err=%b exp 02/0", r_rd, r_err); end
    apb_xfer(1'b1, 4'h4, 8'hFF, -1);
    vectors++; if (r_err !== 1'b1) begin miscompares++; $display("FAIL status_wr err=%b exp 1", r_err); end
    apb_xfer(1'b1, 4'h8, 8'h01, -1);
    vectors++; if (r_err !== 1'b0) begin miscompares++; $display("FAIL ctrl_wr err=%b exp 0", r_err); end
    apb_xfer(1'b0, 4'h8, 8'h00, -1);
    vectors++; if (r_rd !== 8'h01 || r_err !== 1'b0) begin miscompares++; $display("FAIL ctrl_rd1 rd=%h err=%b exp 01/0", r_rd, r_err); end
    apb_xfer(1'b1, 4'h8, 8'hFE, -1);
    apb_xfer(1'b0, 4'h8, 8'h00, -1);
    vectors++; if (r_rd !== 8'h00) begin miscompares++; $display("FAIL ctrl_rd0 rd=%h exp 00", r_rd); end
    apb_xfer(1'b0, 4'h2, 8'h00, -1);
    vectors++; if (r_err !== 1'b1 || r_rd !== 8'h00 || r_rdy !== 2) begin miscompares++; $display("FAIL unmapped rd=%h err=%b rdy=%0d exp 00/1/2", r_rd, r_err, r_rdy); end
  endtask

  task automatic test_block_release();
    apb_xfer(1'b1, 4'h8, 8'h01, -1);
    fifo_full = 1'b0; fifo_empty = 1'b1; fifo_rdata = 8'h3C;
    apb_xfer(1'b0, 4'h0, 8'h00, 5);
    vectors++; if (r_pop !== 1 || r_scyc !== 5) begin miscompares++; $display("FAIL release_pop n=%0d cyc=%0d exp 1/5", r_pop, r_scyc); end
    vectors++; if (r_rdy !== 6 || r_rd !== 8'h3C || r_err !== 1'b0) begin miscompares++; $display("FAIL release_resp rdy=%0d rd=%h err=%b exp 6/3c/0", r_rdy, r_rd, r_err); end
  endtask

  task automatic test_timeout();
    fifo_full = 1'b1; fifo_empty = 1'b0;
    apb_xfer(1'b1, 4'h0, 8'h77, -1);
    vectors++; if (r_rdy !== TIMEOUT + 3 || r_err !== 1'b1 || r_push !== 0) begin miscompares++; $display("FAIL timeout rdy=%0d err=%b push=%0d exp %0d/1/0", r_rdy, r_err, r_push, TIMEOUT + 3); end
  endtask

  task automatic test_abort();
    int pops0;
    fifo_full = 1'b0; fifo_empty = 1'b0;
    apb_xfer(1'b1, 4'h8, 8'h01, -1);
    // psel drop during a stall
    fifo_empty = 1'b1; fifo_rdata = 8'h99;
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
    @(negedge clk); penable = 1'b1;
    repeat (3) @(negedge clk);
    pops0 = tot_pop;
    psel = 1'b0; penable = 1'b0; fifo_empty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL abort_pready cyc=%0d got=%b exp=0", i, pready); end
      @(negedge clk);
    end
    vectors++; if (tot_pop !== pops0) begin miscompares++; $display("FAIL abort_pop got=%0d exp=%0d", tot_pop, pops0); end
    apb_xfer(1'b0, 4'h8, 8'h00, -1);
    vectors++; if (r_rdy !== 2 || r_rd !== 8'h01) begin miscompares++; $display("FAIL abort_idle rdy=%0d rd=%h exp 2/01", r_rdy, r_rd); end
    // reset during a stall
    fifo_empty = 1'b1;
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
    @(negedge clk); penable = 1'b1;
    repeat (3) @(negedge clk);
    pops0 = tot_pop;
    rst = 1'b1; fifo_empty = 1'b0;
    @(negedge clk);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (tot_pop !== pops0 || pready !== 1'b0) begin miscompares++; $display("FAIL rstwait pop=%0d pready=%b exp %0d/0", tot_pop, pready, pops0); end
    apb_xfer(1'b0, 4'h8, 8'h00, -1);
    vectors++; if (r_rd !== 8'h00 || r_err !== 1'b0) begin miscompares++; $display("FAIL rstwait_ctrl rd=%h err=%b exp 00/0", r_rd, r_err); end
  endtask

  task automatic test_errcnt();
`ifdef APB_FIFO_BRIDGE_STATS_EN
    apb_xfer(1'b1, 4'hC, 8'h5C, -1);
    vectors++; if (r_err !== 1'b0) begin miscompares++; $display("FAIL errcnt_clr err=%b exp 0", r_err); end
    for (int i = 0; i < 3; i++) apb_xfer(1'b0, 4'hE, 8'h00, -1);
    apb_xfer(1'b0, 4'hC, 8'h00, -1);
    vectors++; if (r_rd !== 8'd3 || r_err !== 1'b0) begin miscompares++; $display("FAIL errcnt_3 rd=%0d err=%b exp 3/0", r_rd, r_err); end
`else
    apb_xfer(1'b0, 4'hC, 8'h00, -1);
    vectors++; if (r_err !== 1'b1) begin miscompares++; $display("FAIL errcnt_unmapped err=%b exp 1", r_err); end
`endif
  endtask

  task automatic test_random();
    logic [3:0] addrs[8];
    addrs[0] = 4'h0; addrs[1] = 4'h0; addrs[2] = 4'h0; addrs[3] = 4'h4;
    addrs[4] = 4'h8; addrs[5] = 4'hC; addrs[6] = 4'h6; addrs[7] = 4'hB;
    q.delete();
    apb_xfer(1'b1, 4'h8, 8'h00, -1);
    m_block_en = 1'b0;
    apb_xfer(1'b0, 4'h8, 8'h00, -1);
    m_prdata = 8'h00;
`ifdef APB_FIFO_BRIDGE_STATS_EN
    apb_xfer(1'b1, 4'hC, 8'h00, -1);
`endif
    m_errcnt = 0;
    for (int n = 0; n < 80; n++) begin
      logic       wr, full, empty, exp_err;
      logic [3:0] a;
      logic [7:0] wd, exp_pdata;
      int         exp_rdy, exp_push, exp_pop;
      wr = 1'(($urandom % 2));
      a  = addrs[$urandom_range(0, 7)];
      wd = 8'($urandom);
      full  = (q.size() >= DEPTH);
      empty = (q.size() == 0);
      fifo_full  = full;
      fifo_empty = empty;
      fifo_rdata = empty ? 8'hEE : q[0];
      exp_err = 1'b0; exp_rdy = 2; exp_push = 0; exp_pop = 0; exp_pdata = wd;
      case (a)
        4'h0: begin
          if (wr ? full : empty) begin
            exp_err = 1'b1;
            if (m_block_en) exp_rdy = TIMEOUT + 3;
          end else if (wr) begin
            exp_push = 1; q.push_back(wd);
          end else begin
            exp_pop = 1; m_prdata = q.pop_front();
          end
        end
        4'h4: if (wr) exp_err = 1'b1; else m_prdata = {6'b0, full, empty};
        4'h8: if (wr) m_block_en = wd[0]; else m_prdata = {7'b0, m_block_en};
`ifdef APB_FIFO_BRIDGE_STATS_EN
        4'hC: if (wr) m_errcnt = 0; else m_prdata = 8'(m_errcnt);
`endif
        default: exp_err = 1'b1;
      endcase
      if (exp_err && m_errcnt < 255) m_errcnt++;
      apb_xfer(wr, a, wd, -1);
      vectors++;
      if (r_rdy !== exp_rdy || r_err !== exp_err || r_rd !== m_prdata ||
          r_push !== exp_push || r_pop !== exp_pop ||
          (exp_push == 1 && r_pdata !== exp_pdata)) begin
        miscompares++;
        $display("FAIL rand[%0d] wr=%b a=%h got rdy=%0d err=%b rd=%h push=%0d pop=%0d wd=%h exp rdy=%0d err=%b rd=%h push=%0d pop=%0d wd=%h",
                 n, wr, a, r_rdy, r_err, r_rd, r_push, r_pop, r_pdata,
                 exp_rdy, exp_err, m_prdata, exp_push, exp_pop, exp_pdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nonblock_err();
    test_status_ctrl();
    test_block_release();
    test_timeout();
    test_abort();
    test_errcnt();
    test_random();
    @(negedge clk);
    vectors++; if (both_hi !== 0) begin miscompares++; $display("FAIL push_pop_overlap got=%0d exp=0", both_hi); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_fifo_bridge.md
Name: apb_fifo_bridge

Overview:
- APB slave front-end that sits directly upstream of the team's flip-flop FIFO.
- Converts APB register accesses into single-cycle FIFO push/pop strobes.
  - A write to DATA pushes one word.
  - A read from DATA pops one word.
- Exposes FIFO status over APB.
- Optionally stalls the bus (PREADY low) while the FIFO is full or empty, bounded by a timeout.

Parameters:
- width, 8, FIFO word width; also the APB data width used by this block.
- addr_width, 4, APB address width; byte addresses, word-aligned.
- timeout, 15, maximum stall cycles in blocking mode before an error response; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  1 = write, 0 = read
- paddr  in  addr_width  byte address
- pwdata  in  width  write data
- prdata  out  width  read data, registered
- pready  out  1  transfer complete, registered
- pslverr  out  1  error response, valid only with pready
- fifo_push  out  1  one-cycle push strobe
- fifo_wdata  out  width  push data, valid with fifo_push
- fifo_pop  out  1  one-cycle pop strobe
- fifo_rdata  in  width  FIFO head word (combinational from the FIFO)
- fifo_empty  in  1  FIFO empty
- fifo_full  in  1  FIFO full

Behaviour:
- Register map:
  - 0x0 DATA: W pushes, R pops.
  - 0x4 STATUS (RO): bit0 = empty, bit1 = full.
  - 0x8 CTRL (RW): bit0 = block_en.
  - Any other address is unmapped: pslverr=1, no side effect.
  - Writes to STATUS return pslverr=1.
- FSM states: IDLE, WAIT, RESP.
- IDLE, entered on psel & penable:
  - DATA write, !fifo_full: fifo_push=1 and fifo_wdata=pwdata in this cycle; go to RESP.
  - DATA read, !fifo_empty: fifo_pop=1 and prdata<=fifo_rdata in this cycle; go to RESP.
  - Blocked (full on write / empty on read) with block_en=1: go to WAIT, load stall counter with 0.
  - Blocked with block_en=0: go to RESP with pslverr=1; no push or pop.
  - Any other access: register action in this cycle; go to RESP.
- WAIT:
  - Re-evaluates the blocking condition every cycle.
  - When it clears, performs the push/pop in that cycle and goes to RESP.
  - Stall counter increments every cycle.
  - When the counter reaches timeout with the condition still blocked: go to RESP with pslverr=1, no strobe.
  - If psel drops (protocol violation): return to IDLE with no strobe and no response.
- RESP:
  - pready=1 for exactly one cycle, then return to IDLE.
  - pslverr is set as decided above.
  - prdata holds the captured value until the next read completes.
- Latency: an unblocked access completes with one wait state (pready on the 2nd access-phase cycle).
- fifo_push and fifo_pop are never both high in the same cycle, and never high outside IDLE/WAIT.
- Each strobe is at most one cycle per APB transfer.
- Stall counter width is $clog2(timeout+1).
- Reset (synchronous): state=IDLE; prdata=0, pready=0, pslverr=0, fifo_push=0, fifo_pop=0, block_en=0, stall counter=0.
  - Reset mid-WAIT drops the transfer with no strobe.

Optional Feature:
- Macro: APB_FIFO_BRIDGE_STATS_EN
- Defined:
  - Adds register 0xC ERRCNT: 8-bit saturating count of pslverr responses (saturates at 255).
  - A write of any value clears it.
  - A read returns the count zero-extended/truncated to width.
- Undefined: 0xC is unmapped (pslverr=1) and no counter logic exists.

Decomposition:
- Package apb_fifo_bridge_pkg holds:
  - address constants ADDR_DATA, ADDR_STATUS, ADDR_CTRL, ADDR_ERRCNT;
  - enum state_t {IDLE, WAIT, RESP};
  - STATUS/CTRL bit-index constants.
- One natural sub-module: apb_fifo_bridge_decode, a combinational address decode that produces the register hit and unmapped/illegal flags.

Test Plan:
- Write 0x5A to 0x0 with FIFO not full -> fifo_push high for 1 cycle with fifo_wdata=0x5A; pready on the 2nd access cycle, pslverr=0.
- FIFO holding 0xA5, read 0x0 -> fifo_pop for 1 cycle; prdata=0xA5 with pready, pslverr=0.
- block_en=0, fifo_full=1, write 0x0 -> no push; pready with pslverr=1 on the 2nd access cycle.
- block_en=1, fifo_empty=1, read 0x0, empty deasserts after 4 cycles -> pop in that cycle; pready one cycle later, pslverr=0.
- block_en=1, fifo_full held at 1, timeout=15 -> pready+pslverr after the stall counter reaches 15; fifo_push never asserted.
- Read 0x4 with full=1, empty=0 -> prdata=0x02. Write 0x8 -> pslverr=1 reported only for illegal addresses. With STATS_EN defined, after 3 errors a read of 0xC returns 3.
